// File: rtl/seg7_disp_n.sv
// Hex seven-segment driver: static per-digit outputs plus a one-hot multiplexed scan port, with leading-zero blanking and blink.
// Latency: load->oLOAD_ACK 1 edge, ->oSEG/oDP 2 edges; no backpressure, every iLOAD is accepted.
module seg7_disp_n #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1024,
  parameter int BLINK_DIV      = 12500000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iDIG,
  input  logic                    iLOAD,
  input  logic                    iBLANK_LZ,
  input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
  input  logic [NUM_DIGITS-1:0]   iDP,
  output logic [7*NUM_DIGITS-1:0] oSEG,
  output logic [NUM_DIGITS-1:0]   oDP,
  output logic [6:0]              oSCAN_SEG,
  output logic [NUM_DIGITS-1:0]   oSCAN_AN,
  output logic                    oLOAD_ACK
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  logic [4*NUM_DIGITS-1:0] r_dig;
  logic                    r_load_ack;
  logic [SW-1:0]           r_scan_cnt;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_phase;
  logic [IW-1:0]           r_idx;
  logic [7*NUM_DIGITS-1:0] r_seg;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [6:0]              r_scan_seg;
  logic [NUM_DIGITS-1:0]   r_scan_an;

  logic [7*NUM_DIGITS-1:0] w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_dp_nxt;
  logic                    w_run;
  logic [3:0]              w_nib;
  logic [6:0]              w_lit;
  logic                    w_off;
  logic                    w_dp_lit;
  logic                    w_scan_wrap;
  logic                    w_blink_wrap;
  logic [IW-1:0]           w_idx_nxt;

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // The blanking run walks from the top digit down and dies at the first non-zero or DP digit.
  always_comb begin
    w_seg_nxt = '0;
    w_dp_nxt  = '0;
    w_run     = iBLANK_LZ;
    w_nib     = '0;
    w_lit     = '0;
    w_off     = 1'b0;
    w_dp_lit  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_nib    = r_dig[4*i +: 4];
      w_run    = (i != 0) && w_run && (w_nib == 4'h0) && !iDP[i];
      w_off    = w_run || (r_phase && iBLINK_MASK[i]);
      w_lit    = w_off ? 7'h00 : f_hex7(w_nib);
      w_dp_lit = iDP[i] && !(r_phase && iBLINK_MASK[i]);
      w_seg_nxt[7*i +: 7] = ACTIVE_LOW_SEG ? ~w_lit : w_lit;
      w_dp_nxt[i]         = ACTIVE_LOW_SEG ? ~w_dp_lit : w_dp_lit;
    end
  end

  assign w_scan_wrap  = (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_scan_wrap && (NUM_DIGITS > 1)) begin
      w_idx_nxt = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_dig       <= '0;
      r_load_ack  <= 1'b0;
      r_scan_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_idx       <= '0;
      r_seg       <= {NUM_DIGITS{SEG_OFF}};
      r_dp        <= ACTIVE_LOW_SEG ? '1 : '0;
      r_scan_seg  <= SEG_OFF;
      r_scan_an   <= NUM_DIGITS'(1);
    end else begin
      if (iLOAD) r_dig <= iDIG;
      r_load_ack  <= iLOAD;
      r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
      if (w_blink_wrap) r_phase <= ~r_phase;
      r_idx       <= w_idx_nxt;
      r_seg       <= w_seg_nxt;
      r_dp        <= w_dp_nxt;
      // Scan port tracks the same pattern oSEG takes at this edge, so the two never disagree.
      r_scan_seg  <= w_seg_nxt[7*w_idx_nxt +: 7];
      r_scan_an   <= NUM_DIGITS'(1) << w_idx_nxt;
    end
  end

  assign oSEG      = r_seg;
  assign oDP       = r_dp;
  assign oSCAN_SEG = r_scan_seg;
  assign oSCAN_AN  = r_scan_an;
  assign oLOAD_ACK = r_load_ack;

endmodule

// File: tb/tb_seg7_disp_n.sv
// Scoreboard bench for seg7_disp_n: loads and scan steps push expectations, monitors pop on oLOAD_ACK / oSCAN_AN change.
module tb_seg7_disp_n;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dig = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  dp = '0;
  logic [55:0] seg;
  logic [7:0]  dp_o;
  logic [6:0]  scan_seg;
  logic [7:0]  scan_an;
  logic        load_ack;

  int n_chk = 0;
  int n_pass = 0;

  exp_t       q_load[$];
  logic [7:0] q_scan[$];
  exp_t       pend_e;
  bit         pend = 1'b0;
  int         ld_idx = 0;
  bit         scan_en = 1'b0;
  logic [7:0] scan_prev = 8'h01;
  int         scan_cyc = 0;
  logic [7:0][6:0] scan_tab;

  seg7_disp_n #(
    .NUM_DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW_SEG(1'b1)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDIG(dig), .iLOAD(load), .iBLANK_LZ(blank_lz),
    .iBLINK_MASK(blink_mask), .iDP(dp), .oSEG(seg), .oDP(dp_o),
    .oSCAN_SEG(scan_seg), .oSCAN_AN(scan_an), .oLOAD_ACK(load_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [55:0] s, input logic [7:0] d);
    exp_t e;
    e.seg = s;
    e.dp  = d;
    return e;
  endfunction

  // Load monitor: every ack pops one expectation, checked against oSEG/oDP one edge later.
  initial forever begin
    @(negedge clk);
    if (pend) begin
      for (int i = 0; i < 8; i++)
        check($sformatf("load%0d_seg%0d", ld_idx, i), 64'(seg[7*i +: 7]), 64'(pend_e.seg[i]));
      check($sformatf("load%0d_dp", ld_idx), 64'(dp_o), 64'(pend_e.dp));
      pend = 1'b0;
    end
    if (load_ack) begin
      if (q_load.size() == 0) check("spurious_ack", 64'(load_ack), 64'd0);
      else begin
        pend_e = q_load.pop_front();
        pend = 1'b1;
        ld_idx++;
      end
    end
  end

  // Scan monitor: each change of oSCAN_AN pops the next expected anode.
  initial forever begin
    @(negedge clk);
    if (scan_en) begin
      scan_cyc++;
      if (scan_an !== scan_prev) begin
        if (q_scan.size() == 0) check("scan_extra_step", 64'(scan_an), 64'(scan_prev));
        else begin
          logic [7:0] e;
          int k;
          e = q_scan.pop_front();
          k = 0;
          for (int i = 0; i < 8; i++) if (e[i]) k = i;
          check("scan_an", 64'(scan_an), 64'(e));
          check("scan_period", 64'(scan_cyc), 64'd4);
          check("scan_seg", 64'(scan_seg), 64'(scan_tab[k]));
        end
        scan_prev = scan_an;
        scan_cyc = 0;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_seg", 64'(seg), 64'({56{1'b1}}));
    check("rst_dp", 64'(dp_o), 64'hFF);
    check("rst_scan_seg", 64'(scan_seg), 64'h7F);
    check("rst_scan_an", 64'(scan_an), 64'h01);
    check("rst_ack", 64'(load_ack), 64'd0);

    // Release reset with a load on the first edge; scan runs from index 0.
    repeat (2) @(negedge clk);
    dig  = 32'h0123ABCD;
    load = 1'b1;
    q_load.push_back(mk({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}, 8'hFF));
    scan_tab = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21};
    foreach (q_scan[i]) q_scan.delete(i);
    q_scan.push_back(8'h02); q_scan.push_back(8'h04); q_scan.push_back(8'h08);
    q_scan.push_back(8'h10); q_scan.push_back(8'h20); q_scan.push_back(8'h40);
    q_scan.push_back(8'h80); q_scan.push_back(8'h01); q_scan.push_back(8'h02);
    q_scan.push_back(8'h04);
    scan_prev = 8'h01;
    scan_cyc = 0;
    scan_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("first_edge_seg", 64'(seg), 64'({8{7'h40}}));
    check("first_edge_an", 64'(scan_an), 64'h01);
    repeat (41) @(negedge clk);
    scan_en = 1'b0;
    check("scan_q_drained", 64'(q_scan.size()), 64'd0);

    // Leading-zero blanking, then a DP on digit 2 stops the run there.
    blank_lz = 1'b1;
    dig  = 32'h00000050;
    load = 1'b1;
    q_load.push_back(mk({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40}, 8'hFF));
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    dp   = 8'h04;
    load = 1'b1;
    q_load.push_back(mk({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h12, 7'h40}, 8'hFB));
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);

    // Load held for two edges reloads on each.
    blank_lz = 1'b0;
    dp   = 8'h00;
    dig  = 32'h11111111;
    load = 1'b1;
    q_load.push_back(mk({8{7'h79}}, 8'hFF));
    @(negedge clk);
    dig = 32'h22222222;
    q_load.push_back(mk({8{7'h24}}, 8'hFF));
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);

    // Blink on digit 0 from a fresh reset: 8 edges visible, 8 off.
    blink_mask = 8'h01;
    dp = 8'h01;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      bit vis;
      @(negedge clk);
      vis = (((k - 1) / 8) % 2) == 0;
      check($sformatf("blink_d0_e%0d", k), 64'(seg[6:0]), vis ? 64'h40 : 64'h7F);
      check($sformatf("blink_dp0_e%0d", k), 64'(dp_o[0]), vis ? 64'd0 : 64'd1);
      check($sformatf("blink_d1_e%0d", k), 64'(seg[13:7]), 64'h40);
    end

    // Edge 40: load, blink wrap and scan wrap coincide.
    repeat (7) @(negedge clk);
    dig  = 32'h0123ABCD;
    load = 1'b1;
    q_load.push_back(mk({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h7F}, 8'hFF));
    @(negedge clk);
    load = 1'b0;
    check("coinc_scan_an", 64'(scan_an), 64'h04);
    check("coinc_scan_seg", 64'(scan_seg), 64'h40);
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges with iLOAD pending.
    blink_mask = 8'h00;
    dp = 8'h00;
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    dig  = 32'hFFFFFFFF;
    load = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 64'(seg), 64'({56{1'b1}}));
    check("arst_dp", 64'(dp_o), 64'hFF);
    check("arst_scan_seg", 64'(scan_seg), 64'h7F);
    check("arst_scan_an", 64'(scan_an), 64'h01);
    check("arst_ack", 64'(load_ack), 64'd0);
    repeat (2) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_first_seg", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    check("arst_first_dp", 64'(dp_o), 64'hFF);
    check("arst_first_an", 64'(scan_an), 64'h01);
    repeat (3) @(negedge clk);
    check("load_q_drained", 64'(q_load.size() + int'(pend)), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
